backup_restore_ctrl: RTL and testbench
======================================

// Module: backup_restore_ctrl
// PURPOSE
//  Responder side of the core's register backup/restore interface. On backup_req it scans the NREG
//  architectural registers, collects the dirty ones from the core and stores them in a retention store.
//  On restore_req it writes every valid stored value back into the core. Driven by the power CU around
//  stand_by / Pwr_off entry and exit.
// PARAMETERS
//  NREG         53   registers on the backup interface
//  W            32   register width
//  ACK_TIMEOUT  15   cycles to wait for backup_acks before giving up on a register
// PORTS
//  Clk              in   1         clock, all state on rising edge
//  Rst              in   1         asynchronous, active-high reset
//  backup_req       in   1         start backup (sampled in IDLE only)
//  restore_req      in   1         start restore (sampled in IDLE only)
//  clr_store        in   1         sync clear of all shadow_valid bits (IDLE only)
//  busy             out  1         FSM not in IDLE
//  done             out  1         1-cycle pulse when a backup or restore completes
//  err              out  1         sticky: >=1 ack timeout in last backup
//  saved_cnt        out  6         registers stored by the last backup
//  dirty_vals_rv    in   NREG*2    per reg {valid,modified}; bit 2i = modified
//  backup_ens_rv    out  NREG      one-hot request to core: present reg i
//  backup_acks_rv   in   NREG      core: backup_Vouts slice i is valid
//  backup_Vouts_rv  in   NREG*W    register values from core, slice i = [i*W +: W]
//  restore_ens_rv   out  NREG      one-hot 1-cycle write strobe into core reg i
//  restore_Vins_rv  out  NREG*W    restore data; slice i = shadow[i], driven continuously
// BEHAVIOUR
//  Reset (Rst=1, async): state IDLE, idx=0, busy=0, done=0, err=0, saved_cnt=0,
//    backup_ens=0, restore_ens=0, timeout counter=0.
//  Rst does NOT touch shadow[] or shadow_valid[] (retention store). Only clr_store clears them.
//  States: IDLE, BK_SCAN, BK_WAIT, RS_SCAN, DONE.
//  IDLE: backup_req -> clear err and saved_cnt, idx=0, go to BK_SCAN.
//    Otherwise restore_req -> idx=0, go to RS_SCAN. If both are high, backup wins.
//    Requests and clr_store are ignored outside IDLE.
//  BK_SCAN: if dirty bit 2*idx == 0, skip (idx++, 1 cycle).
//    Else assert backup_ens[idx], clear the timer, go to BK_WAIT.
//  BK_WAIT: backup_ens[idx] stays high.
//    backup_acks[idx]=1 -> in that cycle shadow[idx] <= Vouts slice, shadow_valid[idx] <= 1, saved_cnt++;
//      next cycle backup_ens=0, idx++, back to BK_SCAN.
//    ACK_TIMEOUT cycles with no ack -> err=1, store unchanged, idx++, back to BK_SCAN.
//    Acks on other indices are ignored.
//  RS_SCAN: if shadow_valid[idx], pulse restore_ens[idx] for exactly 1 cycle; else skip.
//    Either way idx++ and 1 cycle per register.
//  idx wraps only via completion: after idx == NREG-1 is handled, go to DONE.
//  DONE: done=1 for one cycle, then IDLE.
//  At most one bit of backup_ens / restore_ens is high per cycle; the two are never high together.
//  Latency: backup = NREG + sum over dirty regs of (ack delay + 1) cycles; restore = NREG + 1 cycles.
//  Rst mid-operation: abort at once; enables drop; store keeps any entries already written.
//    No done pulse is generated.
//  NREG=0 dirty: backup takes NREG scan cycles, saved_cnt=0, done still pulses.
// STRUCTURE
//  Shared package: FSM state encoding, NREG/W defaults, the dirty-bit field positions (MOD=0, VALID=1).
//    The core and the power CU import the same package.
//  One natural sub-module: retention_store (NREG x W array + valid bits).
//    Write port, clr input, flat read bus.
//    It has no reset, so it can later map to retention/NV cells.
// TESTING
//  1 clr_store; dirty mod bits at 0, 5, 52; core acks 2 cycles after en with 32'hA0+i
//    -> en one-hot, in index order; saved_cnt=3; done pulses once; err=0.
//  2 After test 1, restore_req -> restore_ens pulses only at 0, 5, 52, one cycle each.
//    Vins slice 5 = 32'hA5; done after 54 cycles.
//  3 Reg 7 dirty, never acked -> backup_ens[7] high 15 cycles, then err=1.
//    shadow_valid[7] stays 0; scan continues to 52.
//  4 backup_req and restore_req asserted in the same IDLE cycle -> backup runs.
//    restore_req during busy is ignored.
//  5 Rst asserted while in BK_WAIT on reg 20 -> all outputs 0 the same cycle.
//    Then restore_req -> regs saved before 20 are restored; reg 20 is not.
//  6 No dirty regs -> saved_cnt=0, no backup_ens activity, done after NREG+1 cycles.

Source files
------------

// File: rtl/backup_restore_ctrl_pkg.sv
// backup_restore_ctrl_pkg: shared sizes, FSM encoding and dirty-bit layout for the register backup/restore interface
package backup_restore_ctrl_pkg;
  localparam int NREG = 53;
  localparam int W = 32;
  localparam int ACK_TIMEOUT = 15;
  localparam int IW = $clog2(NREG);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam int MOD = 0;
  localparam int VALID = 1;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BK_SCAN = 3'd1;
  localparam logic [2:0] S_BK_WAIT = 3'd2;
  localparam logic [2:0] S_RS_SCAN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] i);
    return {{(NREG-1){1'b0}}, 1'b1} << i;
  endfunction
endpackage

// File: rtl/backup_restore_ctrl_retention_store.sv
// retention_store: NREG x W shadow array plus valid bits, flat read bus.
// No reset here: contents must survive core reset and may later map to retention cells.
module retention_store
  import backup_restore_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [W-1:0]      wdata,
  input  logic              clr,
  output logic [NREG*W-1:0] rdata,
  output logic [NREG-1:0]   valid
);
  logic [W-1:0] mem [NREG];
  always_ff @(posedge clk) begin
    if (clr) valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
    if (we) mem[waddr] <= wdata;
  end
  for (genvar g = 0; g < NREG; g++) begin : g_rd
    assign rdata[g*W +: W] = mem[g];
  end
endmodule

// File: rtl/backup_restore_ctrl.sv
// backup_restore_ctrl: scans dirty registers into the retention store on backup, writes valid entries back on restore
module backup_restore_ctrl
  import backup_restore_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              backup_req,
  input  logic              restore_req,
  input  logic              clr_store,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [5:0]        saved_cnt,
  input  logic [2*NREG-1:0] dirty_vals_rv,
  output logic [NREG-1:0]   backup_ens_rv,
  input  logic [NREG-1:0]   backup_acks_rv,
  input  logic [NREG*W-1:0] backup_Vouts_rv,
  output logic [NREG-1:0]   restore_ens_rv,
  output logic [NREG*W-1:0] restore_Vins_rv
);
  logic [2:0] state;
  logic [IW-1:0] idx, idx_nx;
  logic [TW-1:0] tmr;
  logic [NREG-1:0] mod_bits, unused_valid_bits, valid;
  logic [W-1:0] vouts [NREG];
  logic last, ack, tmo;
  for (genvar g = 0; g < NREG; g++) begin : g_slice
    assign mod_bits[g] = dirty_vals_rv[2*g+MOD];
    assign unused_valid_bits[g] = dirty_vals_rv[2*g+VALID];
    assign vouts[g] = backup_Vouts_rv[g*W +: W];
  end
  always_comb begin
    last = idx == IW'(NREG - 1);
    idx_nx = last ? '0 : idx + 1'b1;
    ack = state == S_BK_WAIT && backup_acks_rv[idx];
    tmo = tmr == TW'(ACK_TIMEOUT - 1);
    busy = state != S_IDLE;
    done = state == S_DONE;
    backup_ens_rv = state == S_BK_WAIT ? onehot(idx) : '0;
    restore_ens_rv = (state == S_RS_SCAN && valid[idx]) ? onehot(idx) : '0;
  end
  // An ack in the final timer cycle still counts as a successful save.
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= S_IDLE;
      idx <= '0;
      tmr <= '0;
      err <= 1'b0;
      saved_cnt <= '0;
    end else
      case (state)
        S_IDLE:
          if (backup_req) begin
            state <= S_BK_SCAN;
            idx <= '0;
            err <= 1'b0;
            saved_cnt <= '0;
          end else if (restore_req) begin
            state <= S_RS_SCAN;
            idx <= '0;
          end
        S_BK_SCAN:
          if (mod_bits[idx]) begin
            state <= S_BK_WAIT;
            tmr <= '0;
          end else begin
            state <= last ? S_DONE : S_BK_SCAN;
            idx <= idx_nx;
          end
        S_BK_WAIT: begin
          tmr <= tmr + 1'b1;
          saved_cnt <= saved_cnt + 6'(ack);
          err <= err | (tmo & ~ack);
          if (ack || tmo) begin
            state <= last ? S_DONE : S_BK_SCAN;
            idx <= idx_nx;
          end
        end
        S_RS_SCAN: begin
          state <= last ? S_DONE : S_RS_SCAN;
          idx <= idx_nx;
        end
        default: state <= S_IDLE;
      endcase
  retention_store u_store (
    .clk(Clk),
    .we(ack),
    .waddr(idx),
    .wdata(vouts[idx]),
    .clr(state == S_IDLE && clr_store),
    .rdata(restore_Vins_rv),
    .valid(valid)
  );
endmodule

// File: tb/tb_backup_restore_ctrl.sv
// tb_backup_restore_ctrl: table rows, directed corner sequences and randomized operations checked against a transaction-level model
module tb_backup_restore_ctrl;
  import backup_restore_ctrl_pkg::*;
  localparam int N = NREG;
  typedef struct {
    logic [N-1:0] mask;
    int dly;
    int saved;
    bit err;
    int done_at;
  } row_t;
  logic clk = 1'b0, rst = 1'b1;
  logic backup_req = 1'b0, restore_req = 1'b0, clr_store = 1'b0;
  logic busy, done, err;
  logic [5:0] saved_cnt;
  logic [2*N-1:0] dirty_vals = '0;
  logic [N-1:0] backup_ens, backup_acks = '0, restore_ens;
  logic [N*W-1:0] vouts = '0, vins;
  int vec = 0, bad = 0;
  logic [W-1:0] m_shadow [N];
  bit m_valid [N];
  bit m_err;
  int m_saved;
  logic [N-1:0] dmask;
  int dly [N];
  logic [W-1:0] vbase;
  row_t tbl [7];

  backup_restore_ctrl dut (
    .Clk(clk), .Rst(rst), .backup_req(backup_req), .restore_req(restore_req),
    .clr_store(clr_store), .busy(busy), .done(done), .err(err), .saved_cnt(saved_cnt),
    .dirty_vals_rv(dirty_vals), .backup_ens_rv(backup_ens), .backup_acks_rv(backup_acks),
    .backup_Vouts_rv(vouts), .restore_ens_rv(restore_ens), .restore_Vins_rv(vins)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear();
    @(negedge clk);
    clr_store = 1'b1;
    @(negedge clk);
    clr_store = 1'b0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // One backup or restore; the model predicts order, enable lengths, latency and store contents.
  task automatic run_op(input bit bq, input bit rq, input bit noise, input int abort_at, output int done_at);
    int hi [N];
    int exp_len [N];
    int got_q [$];
    int exp_q [$];
    int c = 0, k = 0, cur = 0, viol = 0, exp_c = N, errs = 0, lim;
    logic [N-1:0] en, prev = '0;
    done_at = 0;
    lim = abort_at >= 0 ? abort_at : N;
    for (int i = 0; i < N; i++) begin
      dirty_vals[2*i+MOD] = dmask[i];
      dirty_vals[2*i+VALID] = 1'($urandom);
      vouts[i*W +: W] = vbase + W'(i);
      hi[i] = 0;
      exp_len[i] = 0;
      if (bq ? dmask[i] : m_valid[i]) begin
        exp_q.push_back(i);
        exp_len[i] = bq ? (dly[i] < ACK_TIMEOUT ? dly[i] + 1 : ACK_TIMEOUT) : 1;
        exp_c += bq ? exp_len[i] : 0;
      end
    end
    if (bq) begin
      m_saved = 0;
      m_err = 1'b0;
      for (int i = 0; i < lim; i++)
        if (dmask[i]) begin
          if (dly[i] < ACK_TIMEOUT) begin
            m_shadow[i] = vbase + W'(i);
            m_valid[i] = 1'b1;
            m_saved++;
          end else m_err = 1'b1;
        end
      if (abort_at >= 0) begin
        m_saved = 0;
        m_err = 1'b0;
      end
    end
    @(negedge clk);
    backup_req = bq;
    restore_req = rq;
    clr_store = 1'b0;
    while (c < 2000 && done_at == 0) begin
      @(negedge clk);
      c++;
      en = bq ? backup_ens : restore_ens;
      viol += int'($countones(backup_ens) > 1 || $countones(restore_ens) > 1 || (|backup_ens && |restore_ens) || !busy);
      k = (en != 0 && en == prev) ? k + 1 : 1;
      for (int i = N - 1; i >= 0; i--) if (en[i]) cur = i;
      if (en != 0 && en != prev) for (int i = 0; i < N; i++) if (en[i]) got_q.push_back(i);
      for (int i = 0; i < N; i++) hi[i] += int'(en[i]);
      prev = en;
      if (abort_at >= 0 && en[abort_at] && k == 3) begin
        rst = 1'b1;
        #1 chk("abort_outs", {busy, done, err, saved_cnt, |backup_ens, |restore_ens}, 0);
        @(negedge clk);
        {rst, backup_req, restore_req, backup_acks} = '0;
        return;
      end
      backup_acks = (bq && en != 0 && k == dly[cur] + 1) ? en :
                    noise ? N'({$urandom(), $urandom()}) & ~backup_ens : '0;
      if (done) begin
        done_at = c;
        {backup_req, restore_req, clr_store} = '0;
      end else if (noise) begin
        backup_req = 1'($urandom);
        restore_req = 1'($urandom);
        clr_store = $urandom_range(0, 7) == 0;
      end
    end
    @(negedge clk);
    backup_acks = '0;
    chk("idle_after_done", {busy, done}, 0);
    chk("done_cycle", done_at, exp_c + 1);
    chk("onehot_busy_viol", viol, 0);
    chk("order_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) errs += int'(got_q[i] != exp_q[i]);
    chk("order", errs, 0);
    errs = 0;
    for (int i = 0; i < N; i++) errs += int'(hi[i] != exp_len[i]);
    chk("en_len", errs, 0);
    chk("saved_cnt", saved_cnt, m_saved);
    chk("err", err, m_err);
    errs = 0;
    for (int i = 0; i < N; i++) errs += int'(m_valid[i] && vins[i*W +: W] !== m_shadow[i]);
    chk("vins", errs, 0);
  endtask

  initial begin
    int d;
    logic [N-1:0] one;
    one = N'(1);
    tbl[0] = '{one | (one << 5) | (one << 52), 2, 3, 1'b0, 63};
    tbl[1] = '{(one << 1) | (one << 2), 0, 2, 1'b0, 56};
    tbl[2] = '{one << 10, 14, 1, 1'b0, 69};
    tbl[3] = '{one << 10, 15, 0, 1'b1, 69};
    tbl[4] = '{{N{1'b1}}, 1, 53, 1'b0, 160};
    tbl[5] = '{'0, 3, 0, 1'b0, 54};
    tbl[6] = '{(one << 7) | (one << 52), 99, 0, 1'b1, 84};
    vbase = 32'hA0;
    foreach (m_valid[i]) begin
      m_valid[i] = 1'b0;
      m_shadow[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, done, err, saved_cnt, |backup_ens, |restore_ens}, 0);
    rst = 1'b0;
    clear();
    for (int r = 0; r < 7; r++) begin
      dmask = tbl[r].mask;
      foreach (dly[i]) dly[i] = tbl[r].dly;
      run_op(1'b1, 1'b0, 1'b0, -1, d);
      chk("tbl_saved", saved_cnt, tbl[r].saved);
      chk("tbl_err", err, tbl[r].err);
      chk("tbl_done_at", d, tbl[r].done_at);
      if (r == 0) begin
        run_op(1'b0, 1'b1, 1'b0, -1, d);
        chk("rs_done_at", d, 54);
        chk("rs_vins5", vins[5*W +: W], 32'hA5);
      end
    end
    dmask = one << 3;
    foreach (dly[i]) dly[i] = 0;
    run_op(1'b1, 1'b1, 1'b0, -1, d);
    chk("both_req_backup_done", d, 55);
    chk("both_req_saved", saved_cnt, 1);
    clear();
    dmask = (one << 3) | (one << 20) | (one << 30);
    foreach (dly[i]) dly[i] = 1;
    dly[20] = 99;
    vbase = 32'h5000;
    run_op(1'b1, 1'b0, 1'b0, 20, d);
    run_op(1'b0, 1'b1, 1'b0, -1, d);
    chk("post_abort_rs_done", d, 54);
    chk("post_abort_vins3", vins[3*W +: W], 32'h5003);
    for (int t = 0; t < 30; t++) begin
      int op;
      op = $urandom_range(0, 9);
      vbase = $urandom();
      if (op == 0) clear();
      else begin
        foreach (dly[i]) begin
          dmask[i] = $urandom_range(0, 5) == 0;
          dly[i] = $urandom_range(0, 17);
        end
        run_op(op < 6, op >= 6 || op == 1, 1'b1, -1, d);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
